interboard_sender: RTL

//  Transmit side of the two-board link. Takes one message from GameControl
//  (ctrl_*) or a reset request, packs it into a 24-bit frame, and sends it as
//  4 x 6-bit chunks over Request/interboard_data. Uses a 4-phase handshake

---
 rtl/interboard_sender_pkg.sv | 47 ++++
 rtl/interboard_sender_ack_synchronizer.sv | 23 ++
 rtl/interboard_sender.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/interboard_sender_pkg.sv
// Shared definitions for the inter-board link: frame geometry, field offsets,
// message encodings, FSM states and the frame packing helper.
package interboard_sender_pkg;

    localparam int unsigned FRAME_W  = 24;
    localparam int unsigned CHUNK_W  = 6;
    localparam int unsigned N_CHUNKS = 4;

    localparam int unsigned RST_BIT      = 23;
    localparam int unsigned MSG_TYPE_LSB = 18;
    localparam int unsigned MOVE_DIR_BIT = 17;
    localparam int unsigned BLOCK_X_LSB  = 12;
    localparam int unsigned BLOCK_Y_LSB  = 9;
    localparam int unsigned CARD_LSB     = 3;
    localparam int unsigned SEL_LEN_LSB  = 0;

    localparam logic [3:0] MSG_NONE   = 4'h0;
    localparam logic [3:0] MSG_MOVE   = 4'h1;
    localparam logic [3:0] MSG_SELECT = 4'h2;
    localparam logic [3:0] MSG_CARD   = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ_HI,
        ST_REQ_LO
    } state_t;

    // Field order matches the frame layout below the rst flag and spare bit
    typedef struct packed {
        logic [3:0] msg_type;
        logic       move_dir;
        logic [4:0] block_x;
        logic [2:0] block_y;
        logic [5:0] card;
        logic [2:0] sel_len;
    } ctrl_msg_t;

    typedef logic [FRAME_W-1:0] frame_t;

    localparam frame_t RST_FRAME = {1'b1, {(FRAME_W-1){1'b0}}};

    function automatic frame_t pack_frame(input logic rst_flag, input ctrl_msg_t msg);
        return {rst_flag, 1'b0, msg};
    endfunction

endpackage

// File: rtl/interboard_sender_ack_synchronizer.sv
// Flop chain bringing the asynchronous remote Ack into the clk domain.
module ack_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/interboard_sender.sv
// Transmit side of the two-board link: packs a message into a 24-bit frame and
// sends it as four 6-bit chunks with a 4-phase Request/Ack handshake.
module interboard_sender
    import interboard_sender_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_en,
    input  logic               ctrl_move_dir,
    input  logic [4:0]         ctrl_block_x,
    input  logic [2:0]         ctrl_block_y,
    input  logic [3:0]         ctrl_msg_type,
    input  logic [5:0]         ctrl_card,
    input  logic [2:0]         ctrl_sel_len,
    input  logic               send_rst,
    input  logic               ack_in,
    output logic               req_out,
    output logic [CHUNK_W-1:0] data_out,
    output logic               drive_en,
    output logic               busy,
    output logic               tx_done,
    output logic               tx_err,
    output logic               overflow
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(N_CHUNKS);

    logic               ack_sync;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   chunk_q, chunk_d;
    frame_t             frame_q, frame_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               pend_valid_q, pend_valid_d;
    frame_t             pend_frame_q, pend_frame_d;

    logic               req_d, drive_d, busy_d, done_d, err_d, ovf_d;
    logic [CHUNK_W-1:0] data_d;
    logic               take_pend, start, rst_unc, ctrl_unc;
    frame_t             next_frame, ctrl_frame;
    ctrl_msg_t          ctrl_msg;

    ack_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ack_in),
        .sync_out (ack_sync)
    );

    always_comb begin
        ctrl_msg.msg_type = ctrl_msg_type;
        ctrl_msg.move_dir = ctrl_move_dir;
        ctrl_msg.block_x  = ctrl_block_x;
        ctrl_msg.block_y  = ctrl_block_y;
        ctrl_msg.card     = ctrl_card;
        ctrl_msg.sel_len  = ctrl_sel_len;
        ctrl_frame        = pack_frame(1'b0, ctrl_msg);
    end

    // State, datapath and registered-output next values
    always_comb begin
        state_d      = state_q;
        chunk_d      = chunk_q;
        frame_d      = frame_q;
        to_cnt_d     = to_cnt_q + TO_W'(1);
        data_d       = data_out;
        done_d       = 1'b0;
        err_d        = 1'b0;
        ovf_d        = 1'b0;
        take_pend    = 1'b0;
        start        = 1'b0;
        next_frame   = ctrl_frame;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (send_rst) begin
                    next_frame = RST_FRAME;
                    start      = 1'b1;
                end else if (pend_valid_q) begin
                    next_frame = pend_frame_q;
                    take_pend  = 1'b1;
                    start      = 1'b1;
                end else if (ctrl_en) begin
                    start = 1'b1;
                end
                if (start) begin
                    state_d = ST_SETUP;
                    chunk_d = '0;
                    frame_d = next_frame;
                    data_d  = next_frame[FRAME_W-1 -: CHUNK_W];
                end
            end
            ST_SETUP: begin
                if (!ack_sync) begin
                    state_d  = ST_REQ_HI;
                    to_cnt_d = '0;
                end
            end
            ST_REQ_HI: begin
                if (ack_sync) begin
                    state_d  = ST_REQ_LO;
                    to_cnt_d = '0;
                end
            end
            ST_REQ_LO: begin
                if (!ack_sync) begin
                    to_cnt_d = '0;
                    if (chunk_q == CNT_W'(N_CHUNKS - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        chunk_d = chunk_q + CNT_W'(1);
                        frame_d = frame_q << CHUNK_W;
                        data_d  = frame_q[FRAME_W-CHUNK_W-1 -: CHUNK_W];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A phase that makes no progress for TIMEOUT_CYCLES drops the frame
        if (state_q != ST_IDLE && state_d == state_q &&
            to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d  = ST_IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end

        if (state_d == ST_IDLE) begin
            data_d = '0;
        end

        // Pending buffer: a reset request may replace a queued ctrl message
        pend_valid_d = pend_valid_q & ~take_pend;
        pend_frame_d = pend_frame_q;
        rst_unc      = send_rst & (state_q != ST_IDLE);
        ctrl_unc     = ctrl_en & ~((state_q == ST_IDLE) & ~send_rst & ~pend_valid_q);
        if (rst_unc) begin
            if (!pend_valid_d || !pend_frame_d[RST_BIT]) begin
                pend_valid_d = 1'b1;
                pend_frame_d = RST_FRAME;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (ctrl_unc) begin
            if (!pend_valid_d) begin
                pend_valid_d = 1'b1;
                pend_frame_d = ctrl_frame;
            end else begin
                ovf_d = 1'b1;
            end
        end

        req_d   = (state_d == ST_REQ_HI);
        drive_d = (state_d != ST_IDLE);
        busy_d  = drive_d | pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            chunk_q      <= '0;
            frame_q      <= '0;
            to_cnt_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_frame_q <= '0;
        end else begin
            state_q      <= state_d;
            chunk_q      <= chunk_d;
            frame_q      <= frame_d;
            to_cnt_q     <= to_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_frame_q <= pend_frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_out  <= 1'b0;
            data_out <= '0;
            drive_en <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            req_out  <= req_d;
            data_out <= data_d;
            drive_en <= drive_d;
            busy     <= busy_d;
            tx_done  <= done_d;
            tx_err   <= err_d;
            overflow <= ovf_d;
        end
    end

endmodule
